// File: rtl/cube2_top.sv
`default_nettype none
// ============================================================================
// Module      : cube2_top
// Description : HUB75 LED-panel controller for the LED cube. Generates an
//               internal test pattern and scans it onto one panel using
//               binary-coded modulation (BCM). Also drives a heartbeat LED.
//               Everything runs from the single 25 MHz oscillator.
//
//               Pattern, per pixel (x, y), all values modulo 2^BPC:
//                 R = x (+ frame count when scrolling), G = y, B = x ^ y
//
//               Build option : define CUBE2_SCROLL_EN to make the red ramp
//                              scroll one column per frame. Without it the
//                              pattern is static and no frame counter is
//                              built. Scan timing is the same in both builds.
//
// Ports       : osc_clk25          in   sole clock, rising edge
//               reset              in   synchronous, active-high
//               hub75_r0/g0/b0     out  upper-half colour bits
//               hub75_r1/g1/b1     out  lower-half colour bits
//               hub75_addr         out  row-pair address
//               hub75_clk          out  panel shift clock
//               hub75_lat          out  latch strobe, active-high
//               hub75_oe_n         out  output enable, active-low
//               led                out  heartbeat
//
// Revision    : 1.0 - initial release
// ============================================================================
module cube2_top #(
    parameter int COLS      = 32,
    parameter int ROW_PAIRS = 16,
    parameter int BPC       = 4,
    parameter int BASE_OE   = 8,
    parameter int HB_W      = 24
) (
    input  logic                         osc_clk25,
    input  logic                         reset,
    output logic                         hub75_r0,
    output logic                         hub75_g0,
    output logic                         hub75_b0,
    output logic                         hub75_r1,
    output logic                         hub75_g1,
    output logic                         hub75_b1,
    output logic [$clog2(ROW_PAIRS)-1:0] hub75_addr,
    output logic                         hub75_clk,
    output logic                         hub75_lat,
    output logic                         hub75_oe_n,
    output logic                         led
);

    localparam int C_A_W   = $clog2(ROW_PAIRS);
    localparam int C_C_W   = $clog2(2 * COLS);
    localparam int C_COL_W = $clog2(COLS);
    localparam int C_Y_W   = $clog2(2 * ROW_PAIRS);
    localparam int C_BIT_W = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int C_D_W   = $clog2(BASE_OE << (BPC - 1)) + 1;

    localparam logic [C_C_W-1:0]   C_C_LAST   = C_C_W'(2 * COLS - 1);
    localparam logic [C_BIT_W-1:0] C_BIT_LAST = C_BIT_W'(BPC - 1);
    localparam logic [C_A_W-1:0]   C_ROW_LAST = C_A_W'(ROW_PAIRS - 1);

    localparam logic [1:0] C_ST_SHIFT = 2'd0;
    localparam logic [1:0] C_ST_LATCH = 2'd1;
    localparam logic [1:0] C_ST_DISP  = 2'd2;

    // Scan state
    logic [1:0]         r_state, w_state_nx;
    logic [C_C_W-1:0]   r_c,     w_c_nx;
    logic [C_BIT_W-1:0] r_bit,   w_bit_nx;
    logic [C_A_W-1:0]   r_row,   w_row_nx;
    logic [C_D_W-1:0]   r_dcnt,  w_dcnt_nx;

    // Registered outputs: {r0, g0, b0, r1, g1, b1}
    logic [5:0]         r_data,  w_data_nx;
    logic               r_sclk,  w_sclk_nx;
    logic               r_lat,   w_lat_nx;
    logic               r_oe_n,  w_oe_n_nx;
    logic [C_A_W-1:0]   r_addr,  w_addr_nx;
    logic [HB_W-1:0]    r_hb;

    logic [C_D_W-1:0]   w_disp_last;
    logic               w_disp_done;
    logic [BPC-1:0]     w_frame_pix;
    logic [C_COL_W-1:0] w_col;
    logic [C_Y_W-1:0]   w_y_hi;
    logic [C_Y_W-1:0]   w_y_lo;
    logic [2:0]         w_pix_hi;
    logic [2:0]         w_pix_lo;

    // Returns {R[b], G[b], B[b]} of pixel (x, y)
    function automatic logic [2:0] f_pix(
        input logic [C_COL_W-1:0] x,
        input logic [C_Y_W-1:0]   y,
        input logic [C_BIT_W-1:0] b,
        input logic [BPC-1:0]     fr
    );
        logic [BPC-1:0] rv;
        logic [BPC-1:0] gv;
        logic [BPC-1:0] bv;
        rv = BPC'(x) + fr;
        gv = BPC'(y);
        bv = BPC'(x) ^ BPC'(y);
        return {rv[b], gv[b], bv[b]};
    endfunction

    assign w_disp_last = (C_D_W'(BASE_OE) << r_bit) - C_D_W'(1);
    assign w_disp_done = (r_state == C_ST_DISP) && (r_dcnt == w_disp_last);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_c_nx     = r_c;
        w_bit_nx   = r_bit;
        w_row_nx   = r_row;
        w_dcnt_nx  = r_dcnt;
        case (r_state)
            C_ST_SHIFT: begin
                if (r_c == C_C_LAST) begin
                    w_state_nx = C_ST_LATCH;
                    w_c_nx     = '0;
                end else begin
                    w_c_nx = r_c + C_C_W'(1);
                end
            end
            C_ST_LATCH: begin
                w_state_nx = C_ST_DISP;
                w_dcnt_nx  = '0;
            end
            C_ST_DISP: begin
                if (w_disp_done) begin
                    w_state_nx = C_ST_SHIFT;
                    w_c_nx     = '0;
                    if (r_bit == C_BIT_LAST) begin
                        w_bit_nx = '0;
                        w_row_nx = (r_row == C_ROW_LAST) ? '0 : r_row + C_A_W'(1);
                    end else begin
                        w_bit_nx = r_bit + C_BIT_W'(1);
                    end
                end else begin
                    w_dcnt_nx = r_dcnt + C_D_W'(1);
                end
            end
            default: begin
                w_state_nx = C_ST_SHIFT;
                w_c_nx     = '0;
            end
        endcase
    end

`ifdef CUBE2_SCROLL_EN
    logic [BPC-1:0] r_frame;
    logic [BPC-1:0] w_frame_nx;

    always_comb begin
        w_frame_nx = r_frame;
        if (w_disp_done && (r_bit == C_BIT_LAST) && (r_row == C_ROW_LAST)) begin
            w_frame_nx = r_frame + BPC'(1);
        end
    end

    always_ff @(posedge osc_clk25) begin
        if (reset) begin
            r_frame <= '0;
        end else begin
            r_frame <= w_frame_nx;
        end
    end

    assign w_frame_pix = w_frame_nx;
`else
    assign w_frame_pix = '0;
`endif

    // ------------------------------------------------------------------------
    // Output logic. Outputs are computed from the *next* scan state so that
    // the registered pins line up with the state the scan is in during the
    // same cycle (no extra pipeline cycle between state and pins).
    // ------------------------------------------------------------------------
    assign w_col    = C_COL_W'(w_c_nx >> 1);
    assign w_y_hi   = C_Y_W'(w_row_nx);
    assign w_y_lo   = C_Y_W'(w_row_nx) + C_Y_W'(ROW_PAIRS);
    assign w_pix_hi = f_pix(w_col, w_y_hi, w_bit_nx, w_frame_pix);
    assign w_pix_lo = f_pix(w_col, w_y_lo, w_bit_nx, w_frame_pix);

    always_comb begin
        w_data_nx = r_data;
        w_sclk_nx = 1'b0;
        w_lat_nx  = 1'b0;
        w_oe_n_nx = 1'b1;
        w_addr_nx = r_addr;
        case (w_state_nx)
            C_ST_SHIFT: begin
                w_data_nx = {w_pix_hi, w_pix_lo};
                w_sclk_nx = w_c_nx[0];
            end
            C_ST_LATCH: begin
                w_lat_nx  = 1'b1;
                w_addr_nx = w_row_nx;
            end
            C_ST_DISP: begin
                w_oe_n_nx = 1'b0;
            end
            default: begin
                w_oe_n_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge osc_clk25) begin
        if (reset) begin
            r_state <= C_ST_SHIFT;
            r_c     <= '0;
            r_bit   <= '0;
            r_row   <= '0;
            r_dcnt  <= '0;
            r_data  <= '0;
            r_sclk  <= 1'b0;
            r_lat   <= 1'b0;
            r_oe_n  <= 1'b1;
            r_addr  <= '0;
            r_hb    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_c     <= w_c_nx;
            r_bit   <= w_bit_nx;
            r_row   <= w_row_nx;
            r_dcnt  <= w_dcnt_nx;
            r_data  <= w_data_nx;
            r_sclk  <= w_sclk_nx;
            r_lat   <= w_lat_nx;
            r_oe_n  <= w_oe_n_nx;
            r_addr  <= w_addr_nx;
            r_hb    <= r_hb + HB_W'(1);
        end
    end

    assign {hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1} = r_data;
    assign hub75_clk  = r_sclk;
    assign hub75_lat  = r_lat;
    assign hub75_oe_n = r_oe_n;
    assign hub75_addr = r_addr;
    assign led        = r_hb[HB_W-1];

endmodule
`default_nettype wire

// File: tb/tb_cube2_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_cube2_top
// Description : Self-checking bench for cube2_top. A cycle-indexed reference
//               model derives every expected pin value from the scan timing
//               and pattern rules with plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cube2_top;

    localparam int COLS      = 32;
    localparam int ROW_PAIRS = 16;
    localparam int BPC       = 4;
    localparam int BASE_OE   = 8;
    localparam int HB_W      = 24;

    localparam int C_AW      = $clog2(ROW_PAIRS);
    localparam int C_OW      = 10 + C_AW;
    localparam int C_OE_BIT  = C_AW + 1;
    localparam int ROW_T     = BPC * (2 * COLS + 1) + BASE_OE * ((1 << BPC) - 1);
    localparam int FRAME_T   = ROW_T * ROW_PAIRS;
`ifdef CUBE2_SCROLL_EN
    localparam int SCROLL    = 1;
`else
    localparam int SCROLL    = 0;
`endif

    // {data(6), clk, lat, oe_n, addr, led} with all-quiet reset levels
    localparam logic [C_OW-1:0] RST_EXP = {6'b0, 1'b0, 1'b0, 1'b1, {C_AW{1'b0}}, 1'b0};

    logic            osc_clk25;
    logic            reset;
    logic            hub75_r0, hub75_g0, hub75_b0;
    logic            hub75_r1, hub75_g1, hub75_b1;
    logic [C_AW-1:0] hub75_addr;
    logic            hub75_clk, hub75_lat, hub75_oe_n, led;
    logic [C_OW-1:0] obs;

    int checks;
    int errors;

    cube2_top #(
        .COLS      (COLS),
        .ROW_PAIRS (ROW_PAIRS),
        .BPC       (BPC),
        .BASE_OE   (BASE_OE),
        .HB_W      (HB_W)
    ) dut (
        .osc_clk25  (osc_clk25),
        .reset      (reset),
        .hub75_r0   (hub75_r0),
        .hub75_g0   (hub75_g0),
        .hub75_b0   (hub75_b0),
        .hub75_r1   (hub75_r1),
        .hub75_g1   (hub75_g1),
        .hub75_b1   (hub75_b1),
        .hub75_addr (hub75_addr),
        .hub75_clk  (hub75_clk),
        .hub75_lat  (hub75_lat),
        .hub75_oe_n (hub75_oe_n),
        .led        (led)
    );

    assign obs = {hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1,
                  hub75_clk, hub75_lat, hub75_oe_n, hub75_addr, led};

    initial osc_clk25 = 1'b0;
    always #20 osc_clk25 = ~osc_clk25;

    // Expected pins during cycle t, where t = 0 is the first cycle after the
    // last clock edge that sampled reset high.
    function automatic logic [C_OW-1:0] model(input int t);
        int fr, rem, row, rt, b, seg, col, xr, yl, a;
        logic shift, latch, disp;
        logic [5:0] d;
        fr  = t / FRAME_T;
        rem = t % FRAME_T;
        row = rem / ROW_T;
        rt  = rem % ROW_T;
        b   = 0;
        seg = 2 * COLS + 1 + BASE_OE;
        while (rt >= seg) begin
            rt  = rt - seg;
            b   = b + 1;
            seg = 2 * COLS + 1 + (BASE_OE << b);
        end
        shift = (rt < 2 * COLS);
        latch = (rt == 2 * COLS);
        disp  = (rt > 2 * COLS);
        col   = shift ? rt / 2 : COLS - 1;
        xr    = col + SCROLL * fr;
        yl    = row + ROW_PAIRS;
        d[5]  = 1'((xr >> b) & 1);
        d[4]  = 1'((row >> b) & 1);
        d[3]  = 1'(((col ^ row) >> b) & 1);
        d[2]  = 1'((xr >> b) & 1);
        d[1]  = 1'((yl >> b) & 1);
        d[0]  = 1'(((col ^ yl) >> b) & 1);
        if (shift && b == 0) a = (row == 0 && fr == 0) ? 0 : (row + ROW_PAIRS - 1) % ROW_PAIRS;
        else                 a = row;
        return {d, 1'(shift && (rt % 2 == 1)), latch, ~disp, C_AW'(a),
                1'((t >> (HB_W - 1)) & 1)};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge osc_clk25);
        @(negedge osc_clk25);
        checks++;
        if (obs !== RST_EXP) begin
            errors++;
            $display("FAIL reset_state got %h want %h", obs, RST_EXP);
        end
        reset = 1'b0;
    endtask

    // Continues straight from test_reset: cycle 0 is the current cycle.
    task automatic test_scan_frame();
        logic [C_OW-1:0] exp;
        logic            prev_clk;
        int              rises;
        int              oe_low;
        prev_clk = 1'b0;
        rises    = 0;
        oe_low   = 0;
        for (int t = 0; t <= FRAME_T + ROW_T; t++) begin
            if (t > 0) @(negedge osc_clk25);
            exp = model(t);
            checks++;
            if (obs !== exp) begin
                errors++;
                if (errors < 20) $display("FAIL scan t=%0d got %h want %h", t, obs, exp);
            end
            if (t <= 2 * COLS && hub75_clk === 1'b1 && prev_clk === 1'b0) rises++;
            prev_clk = hub75_clk;
            if (t > 2 * COLS && t <= 2 * COLS + BASE_OE && hub75_oe_n === 1'b0) oe_low++;
            if (t == 2 * COLS) begin
                checks++;
                if (hub75_lat !== 1'b1) begin
                    errors++;
                    $display("FAIL first_latch got %b want 1", hub75_lat);
                end
            end
            if (t == 2 * COLS + BASE_OE + 1) begin
                checks++;
                if (hub75_oe_n !== 1'b1) begin
                    errors++;
                    $display("FAIL bit1_shift_oe got %b want 1", hub75_oe_n);
                end
            end
            if (t == ROW_T + 2 * COLS) begin
                checks++;
                if (hub75_addr !== C_AW'(1) || hub75_lat !== 1'b1) begin
                    errors++;
                    $display("FAIL row1_latch addr=%0d lat=%b want addr=1 lat=1", hub75_addr, hub75_lat);
                end
            end
            if (t == FRAME_T + 2 * COLS) begin
                checks++;
                if (hub75_addr !== '0 || hub75_lat !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_wrap addr=%0d lat=%b want addr=0 lat=1", hub75_addr, hub75_lat);
                end
            end
            if (t == FRAME_T + 1) begin
                checks++;
                if (hub75_r0 !== 1'(SCROLL == 0 ? 0 : 1)) begin
                    errors++;
                    $display("FAIL frame1_r0 got %b want %0d", hub75_r0, SCROLL);
                end
            end
        end
        checks++;
        if (rises !== COLS) begin
            errors++;
            $display("FAIL shift_rises got %0d want %0d", rises, COLS);
        end
        checks++;
        if (oe_low !== BASE_OE) begin
            errors++;
            $display("FAIL bit0_display_len got %0d want %0d", oe_low, BASE_OE);
        end
    endtask

    task automatic test_reset_mid_display();
        logic [C_OW-1:0] exp;
        int              target;
        int              t;
        for (int k = 0; k < 3; k++) begin
            target = int'($urandom_range(2 * COLS + 1, 3 * ROW_T));
            reset  = 1'b1;
            repeat (int'($urandom_range(1, 4))) @(posedge osc_clk25);
            @(negedge osc_clk25);
            reset = 1'b0;
            t     = 0;
            exp   = model(0);
            while ((t < target || exp[C_OE_BIT] !== 1'b0) && t < target + ROW_T) begin
                checks++;
                if (obs !== exp) begin
                    errors++;
                    if (errors < 20) $display("FAIL pre_reset t=%0d got %h want %h", t, obs, exp);
                end
                @(negedge osc_clk25);
                t++;
                exp = model(t);
            end
            checks++;
            if (obs !== exp || exp[C_OE_BIT] !== 1'b0) begin
                errors++;
                $display("FAIL display_reached t=%0d got %h want %h", t, obs, exp);
            end
            reset = 1'b1;
            @(negedge osc_clk25);
            checks++;
            if (hub75_oe_n !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_oe got %b want 1", hub75_oe_n);
            end
            checks++;
            if (obs !== RST_EXP) begin
                errors++;
                $display("FAIL mid_reset_state got %h want %h", obs, RST_EXP);
            end
            reset = 1'b0;
            for (int n = 1; n <= ROW_T + 2 * COLS + 2; n++) begin
                @(negedge osc_clk25);
                exp = model(n);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    if (errors < 20) $display("FAIL restart t=%0d got %h want %h", n, obs, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [C_OW-1:0] exp;
        int              len;
        for (int k = 0; k < 4; k++) begin
            len   = int'($urandom_range(50, 1500));
            reset = 1'b1;
            repeat (int'($urandom_range(1, 4))) @(posedge osc_clk25);
            @(negedge osc_clk25);
            reset = 1'b0;
            for (int t = 0; t <= len; t++) begin
                if (t > 0) @(negedge osc_clk25);
                exp = model(t);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    if (errors < 20) $display("FAIL window%0d t=%0d got %h want %h", k, t, obs, exp);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset();
        test_scan_frame();
        test_reset_mid_display();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
